// File: rtl/bch_chien_search.sv
// Chien search for a binary BCH decoder: evaluates the error-locator polynomial at every
// codeword position (highest first), emitting one error flag per bit plus root count / failure.
module bch_chien_search #(
  parameter int m      = 4,
  parameter int k_max  = 5,
  parameter int d      = 7,
  parameter int n      = 15,
  parameter int irrpol = 19,
  parameter int ptr_w  = 4,
  localparam int t     = (d - 1) / 2,
  localparam int num_w = (t + 1 > 1) ? $clog2(t + 1) : 1
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             iclkena,
  input  logic             iloc_poly_val,
  input  logic [m-1:0]     iloc_poly [0:t],
  input  logic [ptr_w-1:0] iloc_poly_ptr,
  output logic             ordy,
  output logic             oerr_val,
  output logic             oerr_sop,
  output logic             oerr_eop,
  output logic             oerr,
  output logic [ptr_w-1:0] oerr_ptr,
  output logic [num_w-1:0] oerr_num,
  output logic             odecfail
);

  localparam int nfield = (1 << m) - 1;
  localparam int pos_w  = (n > 1) ? $clog2(n) : 1;

  if (k_max > n || n > nfield) begin : g_bad_params
    $error("bch_chien_search: invalid code parameters");
  end

  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] acc;
    logic [m-1:0] sh;
    logic [m-1:0] poly;
    poly = irrpol[m-1:0];
    acc  = '0;
    sh   = a;
    for (int i = 0; i < m; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[m-1] ? ({sh[m-2:0], 1'b0} ^ poly) : {sh[m-2:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [m-1:0] gf_alpha_pow(input int e);
    logic [m-1:0] r;
    logic [m-1:0] alpha;
    r        = '0;
    r[0]     = 1'b1;
    alpha    = '0;
    alpha[1] = 1'b1;
    for (int i = 0; i < nfield; i++) begin
      if (i < (e % nfield)) r = gf_mul(r, alpha);
    end
    return r;
  endfunction

  typedef enum logic {S_WAIT, S_SEARCH} state_t;

  state_t           state_q, state_d;
  logic [pos_w-1:0] pos_q, pos_d;
  logic [num_w-1:0] cnt_q, cnt_d;
  logic [num_w-1:0] deg_q, deg_d;
  logic [ptr_w-1:0] ptr_q, ptr_d;
  logic [m-1:0]     loc_q [0:t];
  logic [m-1:0]     loc_d [0:t];

  logic [m-1:0]     load_c [0:t];
  logic [m-1:0]     step_c [0:t];

  // Load constants pre-rotate so the first evaluation lands on position n-1 (shortened codes).
  for (genvar gi = 0; gi <= t; gi++) begin : g_const
    localparam logic [m-1:0] c_load = gf_alpha_pow(gi * (nfield - n + 1));
    localparam logic [m-1:0] c_step = gf_alpha_pow(gi);
    assign load_c[gi] = c_load;
    assign step_c[gi] = c_step;
  end

  logic [m-1:0]     sum;
  logic             root;
  logic             last;
  logic             accept;
  logic [num_w-1:0] cnt_total;
  logic [num_w-1:0] deg_in;

  always_comb begin
    sum = '0;
    for (int i = 0; i <= t; i++) sum = sum ^ loc_q[i];
    root   = (state_q == S_SEARCH) && (sum == '0);
    last   = (state_q == S_SEARCH) && (pos_q == '0);
    ordy   = (state_q == S_WAIT) || last;
    accept = iclkena && iloc_poly_val && ordy;
    cnt_total = (cnt_q == num_w'(t)) ? cnt_q : cnt_q + num_w'(root);
    deg_in = '0;
    for (int i = 0; i <= t; i++) begin
      if (iloc_poly[i] != '0) deg_in = num_w'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    deg_d   = deg_q;
    ptr_d   = ptr_q;
    for (int i = 0; i <= t; i++) loc_d[i] = loc_q[i];
    if (iclkena) begin
      if (accept) begin
        state_d = S_SEARCH;
        pos_d   = pos_w'(n - 1);
        cnt_d   = '0;
        deg_d   = deg_in;
        ptr_d   = iloc_poly_ptr;
        for (int i = 0; i <= t; i++) loc_d[i] = gf_mul(iloc_poly[i], load_c[i]);
      end else if (state_q == S_SEARCH) begin
        cnt_d = cnt_total;
        if (last) state_d = S_WAIT;
        else      pos_d   = pos_q - 1'b1;
        for (int i = 0; i <= t; i++) loc_d[i] = gf_mul(loc_q[i], step_c[i]);
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= S_WAIT;
      pos_q   <= '0;
      cnt_q   <= '0;
      deg_q   <= '0;
      for (int i = 0; i <= t; i++) loc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      deg_q   <= deg_d;
      for (int i = 0; i <= t; i++) loc_q[i] <= loc_d[i];
    end
  end

  // The frame pointer is intentionally left out of reset.
  always_ff @(posedge iclk) begin
    ptr_q <= ptr_d;
  end

  // Λ(0)=0 or a root count that disagrees with deg(Λ) means the word was not correctable.
  always_comb begin
    oerr_val = (state_q == S_SEARCH);
    oerr_sop = (state_q == S_SEARCH) && (pos_q == pos_w'(n - 1));
    oerr_eop = last;
    oerr     = root;
    oerr_ptr = ptr_q;
    oerr_num = last ? cnt_total : '0;
    odecfail = last && ((loc_q[0] == '0) || (cnt_total != deg_q));
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Scoreboard bench for bch_chien_search: a full-length (n=15) and a shortened (n=10) instance,
// expected beats derived by direct evaluation of Λ(α^-p) with log/antilog tables.
module tb_bch_chien_search;

  typedef struct {
    int         pos;
    logic [3:0] ptr;
    logic       sop;
    logic       eop;
    logic       err;
    logic [1:0] num;
    logic       fail;
  } beat_t;

  logic       iclk = 1'b0;
  logic       ireset;
  logic       iclkena;

  logic       a_val, a_rdy, a_ev, a_sop, a_eop, a_err, a_fail;
  logic [3:0] a_poly [0:3];
  logic [3:0] a_ptr, a_optr;
  logic [1:0] a_num;

  logic       b_val, b_rdy, b_ev, b_sop, b_eop, b_err, b_fail;
  logic [3:0] b_poly [0:3];
  logic [3:0] b_ptr, b_optr;
  logic [1:0] b_num;

  beat_t      qa[$];
  beat_t      qb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_t [0:14];
  int         log_t [0:15];

  always #5 iclk = ~iclk;

  bch_chien_search #(.m(4), .k_max(5), .d(7), .n(15), .irrpol(19), .ptr_w(4)) dut_a (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iloc_poly_val(a_val), .iloc_poly(a_poly), .iloc_poly_ptr(a_ptr),
    .ordy(a_rdy), .oerr_val(a_ev), .oerr_sop(a_sop), .oerr_eop(a_eop), .oerr(a_err),
    .oerr_ptr(a_optr), .oerr_num(a_num), .odecfail(a_fail)
  );

  bch_chien_search #(.m(4), .k_max(5), .d(7), .n(10), .irrpol(19), .ptr_w(4)) dut_b (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iloc_poly_val(b_val), .iloc_poly(b_poly), .iloc_poly_ptr(b_ptr),
    .ordy(b_rdy), .oerr_val(b_ev), .oerr_sop(b_sop), .oerr_eop(b_eop), .oerr(b_err),
    .oerr_ptr(b_optr), .oerr_num(b_num), .odecfail(b_fail)
  );

  function automatic logic [3:0] eval_at_pos(input logic [0:3][3:0] p, input int pos);
    logic [3:0] acc;
    int e;
    acc = '0;
    e   = (15 - (pos % 15)) % 15;
    for (int i = 0; i < 4; i++) begin
      if (p[i] != 4'd0) acc = acc ^ exp_t[(log_t[p[i]] + e * i) % 15];
    end
    return acc;
  endfunction

  task automatic push_frame(input bit sel, input logic [0:3][3:0] p, input logic [3:0] ptr, input int nn);
    beat_t b;
    int roots;
    int deg;
    roots = 0;
    deg   = 0;
    for (int i = 0; i < 4; i++) if (p[i] != 4'd0) deg = i;
    for (int k = 0; k < nn; k++) begin
      b.pos  = nn - 1 - k;
      b.ptr  = ptr;
      b.sop  = (k == 0);
      b.eop  = (k == nn - 1);
      b.err  = (eval_at_pos(p, b.pos) == 4'd0);
      if (b.err) roots++;
      b.num  = (roots > 3) ? 2'd3 : 2'(roots);
      b.fail = (p[0] == 4'd0) || (roots != deg);
      if (sel) qb.push_back(b);
      else     qa.push_back(b);
    end
  endtask

  always @(negedge iclk) begin : mon_a
    beat_t e;
    if (!ireset && iclkena && a_ev) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL beat_a_unexpected: got beat ptr=%0d err=%0d, required no beat", a_optr, a_err);
      end else begin
        e = qa.pop_front();
        if ({a_optr, a_sop, a_eop, a_err} !== {e.ptr, e.sop, e.eop, e.err}) begin
          errors++;
          $display("FAIL beat_a pos=%0d: got ptr=%0d sop=%0d eop=%0d err=%0d, required ptr=%0d sop=%0d eop=%0d err=%0d",
                   e.pos, a_optr, a_sop, a_eop, a_err, e.ptr, e.sop, e.eop, e.err);
        end
        if (e.eop) begin
          checks++;
          if ({a_num, a_fail} !== {e.num, e.fail}) begin
            errors++;
            $display("FAIL eop_a_status: got num=%0d decfail=%0d, required num=%0d decfail=%0d",
                     a_num, a_fail, e.num, e.fail);
          end
        end
      end
    end
  end

  always @(negedge iclk) begin : mon_b
    beat_t e;
    if (!ireset && iclkena && b_ev) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL beat_b_unexpected: got beat ptr=%0d err=%0d, required no beat", b_optr, b_err);
      end else begin
        e = qb.pop_front();
        if ({b_optr, b_sop, b_eop, b_err} !== {e.ptr, e.sop, e.eop, e.err}) begin
          errors++;
          $display("FAIL beat_b pos=%0d: got ptr=%0d sop=%0d eop=%0d err=%0d, required ptr=%0d sop=%0d eop=%0d err=%0d",
                   e.pos, b_optr, b_sop, b_eop, b_err, e.ptr, e.sop, e.eop, e.err);
        end
        if (e.eop) begin
          checks++;
          if ({b_num, b_fail} !== {e.num, e.fail}) begin
            errors++;
            $display("FAIL eop_b_status: got num=%0d decfail=%0d, required num=%0d decfail=%0d",
                     b_num, b_fail, e.num, e.fail);
          end
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [0:3][3:0] p, input logic [3:0] ptr);
    int waited;
    waited = 0;
    while (!(sel ? b_rdy : a_rdy) && waited < 100) begin
      @(posedge iclk); #1;
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("FAIL ordy_timeout: ordy=0 after 100 cycles, required 1");
    end
    for (int i = 0; i < 4; i++) begin
      if (sel) b_poly[i] = p[i];
      else     a_poly[i] = p[i];
    end
    if (sel) begin b_val = 1'b1; b_ptr = ptr; end
    else     begin a_val = 1'b1; a_ptr = ptr; end
    push_frame(sel, p, ptr, sel ? 10 : 15);
    @(posedge iclk); #1;
    a_val = 1'b0;
    b_val = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while ((qa.size() != 0 || qb.size() != 0) && waited < 200) begin
      @(posedge iclk); #1;
      waited++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d/%0d beats outstanding, required 0", name, qa.size(), qb.size());
    end
    @(posedge iclk); #1;
  endtask

  task automatic test_reset();
    ireset  = 1'b1;
    iclkena = 1'b1;
    a_val = 1'b0; b_val = 1'b0;
    a_ptr = '0;   b_ptr = '0;
    for (int i = 0; i < 4; i++) begin a_poly[i] = '0; b_poly[i] = '0; end
    repeat (3) @(posedge iclk);
    #1;
    checks++;
    if ({a_rdy, a_ev, a_sop, a_eop, a_err, a_num, a_fail} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_a: got rdy=%0d val=%0d sop=%0d eop=%0d err=%0d num=%0d fail=%0d, required rdy=1 others 0",
               a_rdy, a_ev, a_sop, a_eop, a_err, a_num, a_fail);
    end
    checks++;
    if ({b_rdy, b_ev} !== 2'b10) begin
      errors++;
      $display("FAIL reset_b: got rdy=%0d val=%0d, required rdy=1 val=0", b_rdy, b_ev);
    end
    ireset = 1'b0;
    @(posedge iclk); #1;
  endtask

  task automatic test_no_error();
    send(1'b0, {4'd1, 4'd0, 4'd0, 4'd0}, 4'd1);
    drain("no_error");
  endtask

  task automatic test_single();
    send(1'b0, {4'd1, 4'd6, 4'd0, 4'd0}, 4'd2);
    drain("single");
  endtask

  task automatic test_double();
    send(1'b0, {4'd1, 4'd14, 4'd14, 4'd0}, 4'd3);
    drain("double");
  endtask

  task automatic test_shortened();
    send(1'b1, {4'd1, 4'd15, 4'd0, 4'd0}, 4'd7);
    drain("shortened");
  endtask

  task automatic test_ignored_strobe();
    send(1'b0, {4'd1, 4'd6, 4'd0, 4'd0}, 4'd3);
    repeat (3) begin @(posedge iclk); #1; end
    a_val = 1'b1;
    a_ptr = 4'd5;
    a_poly[0] = 4'd1; a_poly[1] = 4'd14; a_poly[2] = 4'd14; a_poly[3] = 4'd0;
    checks++;
    if (a_rdy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ordy: got ordy=%0d at beat 3, required 0", a_rdy);
    end
    @(posedge iclk); #1;
    a_val = 1'b0;
    drain("ignored_strobe");
  endtask

  task automatic test_back_to_back();
    send(1'b0, {4'd1, 4'd14, 4'd14, 4'd0}, 4'd1);
    send(1'b0, {4'd1, 4'd6, 4'd0, 4'd0}, 4'd2);
    checks++;
    if ({a_ev, a_sop, a_optr} !== {1'b1, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL back_to_back_sop: got val=%0d sop=%0d ptr=%0d, required val=1 sop=1 ptr=2",
               a_ev, a_sop, a_optr);
    end
    drain("back_to_back");
  endtask

  task automatic test_clock_enable();
    beat_t e;
    send(1'b0, {4'd1, 4'd10, 4'd0, 4'd0}, 4'd4);
    repeat (5) begin @(posedge iclk); #1; end
    iclkena = 1'b0;
    e = qa[0];
    for (int c = 0; c < 4; c++) begin
      @(posedge iclk); #1;
      checks++;
      if ({a_ev, a_sop, a_eop, a_err, a_optr} !== {1'b1, e.sop, e.eop, e.err, e.ptr}) begin
        errors++;
        $display("FAIL freeze cycle %0d: got val=%0d sop=%0d eop=%0d err=%0d ptr=%0d, required val=1 sop=%0d eop=%0d err=%0d ptr=%0d",
                 c, a_ev, a_sop, a_eop, a_err, a_optr, e.sop, e.eop, e.err, e.ptr);
      end
    end
    iclkena = 1'b1;
    drain("clock_enable");
  endtask

  task automatic test_reset_mid();
    send(1'b0, {4'd1, 4'd14, 4'd14, 4'd0}, 4'd6);
    repeat (7) begin @(posedge iclk); #1; end
    ireset = 1'b1;
    #1;
    checks++;
    if ({a_ev, a_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid: got val=%0d ordy=%0d, required val=0 ordy=1", a_ev, a_rdy);
    end
    qa.delete();
    @(posedge iclk); #1;
    ireset = 1'b0;
    repeat (3) begin
      @(posedge iclk); #1;
      checks++;
      if (a_ev !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle: got val=%0d, required 0", a_ev);
      end
    end
    send(1'b0, {4'd1, 4'd6, 4'd0, 4'd0}, 4'd8);
    drain("after_reset");
  endtask

  initial begin
    logic [4:0] v;
    exp_t[0] = 4'd1;
    log_t[0] = 0;
    log_t[1] = 0;
    for (int i = 1; i < 15; i++) begin
      v = {exp_t[i-1], 1'b0};
      if (v[4]) v = v ^ 5'b10011;
      exp_t[i] = v[3:0];
    end
    for (int i = 0; i < 15; i++) log_t[exp_t[i]] = i;

    test_reset();
    test_no_error();
    test_single();
    test_double();
    test_shortened();
    test_ignored_strobe();
    test_back_to_back();
    test_clock_enable();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
- Downstream stage of the BCH Berlekamp solver. Takes the error-locator polynomial Λ(x) and runs a Chien search over every codeword position.
- Emits one error flag per position, in codeword reception order (highest degree first). This stream is XORed with the delayed codeword in the decoder top.
- Counts roots and flags decoder failure when the root count does not match the degree of Λ.

Parameters:
- m, 4: GF(2^m) symbol width.
- k_max, 5: maximum data bits. Not used internally; kept for interface parity.
- d, 7: code distance. t = (d-1)/2 and t2 = 2t, from bch_parameters.svh.
- n, 15: codeword length in bits, n <= 2^m-1. Shortened codes are supported.
- irrpol, 19: field primitive polynomial (x^4+x+1 for m=4).

Ports:
- iclk  in  1  clock.
- ireset  in  1  asynchronous active-high reset.
- iclkena  in  1  clock enable. All state, including outputs, holds when low.
- iloc_poly_val  in  1  locator polynomial strobe. Accepted only while ordy=1.
- iloc_poly  in  [0:t] x m  Λ coefficients, index = power of x.
- iloc_poly_ptr  in  ptr_t  buffer pointer linked with the codeword.
- ordy  out  1  ready to accept a new polynomial.
- oerr_val  out  1  error flag beat valid.
- oerr_sop  out  1  first beat (position n-1).
- oerr_eop  out  1  last beat (position 0).
- oerr  out  1  1 = bit at this position is in error.
- oerr_ptr  out  ptr_t  pointer latched at acceptance, stable for the whole frame.
- oerr_num  out  clogb2(t+1)  number of roots found. Valid with oerr_eop.
- odecfail  out  1  decoder failure. Valid with oerr_eop.

Behaviour:
- Reset (async, active-high): state=WAIT, ordy=1. oerr_val, oerr_sop, oerr_eop, oerr, odecfail and oerr_num = 0. oerr_ptr is not reset.
- FSM states:
  - WAIT → SEARCH on accepted iloc_poly_val.
  - SEARCH → WAIT after the beat for position 0, unless a new polynomial is accepted on that same beat, in which case it stays in SEARCH.
- ordy = (state==WAIT) | (state==SEARCH & current position==0). A strobe while ordy=0 is ignored; no state change.
- Acceptance loads registers reg[i] = iloc_poly[i] · α^(i·(N-n+1) mod N), i=0..t, with N=2^m-1. The constant powers are computed with gf functions at elaboration. This places the first evaluation at x = α^-(n-1).
- Acceptance also latches the pointer and the degree deg = highest index with nonzero coefficient, and clears the root counter.
- Each SEARCH cycle:
  - sum = XOR of all reg[i]; oerr = (sum==0).
  - Then reg[i] <= reg[i]·α^i, using t constant multipliers.
  - The position counter runs n-1 down to 0.
- Latency: the first oerr_val beat is the cycle after acceptance. Exactly n consecutive beats follow with no gaps while iclkena=1.
- oerr_sop is asserted on beat 0 (position n-1). oerr_eop is asserted on beat n-1 (position 0).
- Root counter saturates at t.
- oerr_num and odecfail are combinational from the final count and update on the eop beat.
- odecfail = (iloc_poly[0]==0) | (roots+current root != deg). In the failure case the oerr flags are still output as computed; the top level decides whether to apply them.
- Back-to-back: a polynomial accepted on the eop beat starts a new sop on the next cycle. oerr_ptr switches on that cycle.
- Λ = 1 (deg 0): all flags 0, oerr_num=0, odecfail=0.
- Reset mid-frame aborts the search. The frame is lost; no eop is produced.

Test Plan:
- m=4, n=15, d=7, Λ=[1,0,0,0] → 15 beats, sop on beat 0, eop on beat 14, all oerr=0, oerr_num=0, odecfail=0.
- Single error, Λ=[1,α^5=6,0,0] → only beat 9 (position 5) has oerr=1; oerr_num=1, odecfail=0.
- Double error, Λ=[1,14,14,0] (=(1+α^2x)(1+α^9x)) → oerr=1 on beats 5 and 12; oerr_num=2, odecfail=0.
- Shortened n=10, Λ=[1,α^12=15,0,0] (root at position 12, outside the code) → no flags, oerr_num=0, odecfail=1 at eop (beat 9).
- Handshake:
  - Second strobe at beat 3 is ignored, ptr unchanged.
  - Strobe with ptr=2 on the eop beat is accepted; the next cycle is the sop of the new frame with oerr_ptr=2 and no gap.
- Hold iclkena=0 for 4 cycles mid-frame → outputs frozen; sequence resumes identically. Assert ireset at beat 7 → oerr_val=0 immediately, ordy=1.
